fetch_unit: RTL

Instruction fetch stage feeding the main decoder. Holds the PC, issues word fetches to instruction memory over a request/valid handshake, and latches the returned word into an instruction register whose opcode field drives the decoder's `op` input. Consumes the decoder's `Branch`/`Jump` outputs plus the execute-stage zero flag and target address to select the next PC when the current instruction retires.

---
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Holds the PC, requests one instruction word at a
// time from instruction memory, latches the returned word into an instruction
// register and presents its opcode field to the main decoder. When the execute
// stage retires the held instruction, the next PC is chosen from the decoder's
// Branch/Jump controls, the ALU zero flag and the execute-stage target.
//
// Handshake: o_imem_req is high for every cycle spent in FETCH, with
// o_imem_addr = o_pc. A word is accepted on the first rising edge in FETCH
// where i_imem_rvalid is high (it may already be high in the first request
// cycle). i_imem_rvalid outside FETCH and i_retire outside HOLD are ignored.
// i_retire in HOLD consumes the instruction on that edge.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined     : a taken branch/jump to a target with [1:0] != 0 enters HALT
//                 and sets the sticky o_misalign_err (cleared only by reset).
//   not defined : target bits [1:0] are forced to zero; HALT is unreachable
//                 and o_misalign_err is tied low.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   o_imem_req/o_imem_addr  fetch request and address
//   i_imem_rvalid/rdata     fetch response
//   o_instr, o_instr_valid  instruction register and its valid flag
//   o_op                    opcode to the decoder (zero when nothing is held)
//   o_pc, o_pc_plus4        address of o_instr and its successor
//   i_retire                execute stage consumed o_instr
//   i_branch, i_jump        decoder controls for the held instruction
//   i_zero, i_pc_target     ALU zero flag and branch/jump target
//   o_misalign_err          sticky misaligned-target flag
//   o_state                 debug view of the FSM state
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic [31:0]     o_instr,
  output logic            o_instr_valid,
  output logic [6:0]      o_op,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  input  logic            i_retire,
  input  logic            i_branch,
  input  logic            i_jump,
  input  logic            i_zero,
  input  logic [XLEN-1:0] i_pc_target,
  output logic            o_misalign_err,
  output logic [1:0]      o_state
);

  typedef enum logic [1:0] {
    ST_RST_WAIT = 2'd0,
    ST_FETCH    = 2'd1,
    ST_HOLD     = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_instr_valid;

  logic            w_capture;
  logic            w_advance;
  logic            w_taken;
  logic            w_misaligned;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_next_pc;

  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_taken    = i_jump | (i_branch & i_zero);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_target     = i_pc_target;
  assign w_misaligned = w_taken & (i_pc_target[1:0] != 2'b00);
`else
  // Low target bits are discarded so the PC always stays word aligned.
  logic w_unused_tgt_lsbs;
  assign w_unused_tgt_lsbs = ^i_pc_target[1:0];
  assign w_target          = {i_pc_target[XLEN-1:2], 2'b00};
  assign w_misaligned      = 1'b0;
`endif

  assign w_next_pc = w_taken ? w_target : w_pc_plus4;

  // Next-state logic; w_capture / w_advance qualify the datapath updates.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      ST_RST_WAIT: w_state_next = ST_FETCH;
      ST_FETCH: begin
        if (i_imem_rvalid) begin
          w_capture    = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_retire) begin
          if (w_misaligned) begin
            w_state_next = ST_HALT;
          end else begin
            w_advance    = 1'b1;
            w_state_next = ST_FETCH;
          end
        end
      end
      ST_HALT:  w_state_next = ST_HALT;
      default:  w_state_next = ST_RST_WAIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_RST_WAIT;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_instr       <= i_imem_rdata;
        r_instr_valid <= 1'b1;
      end
      // Any retire clears valid; the PC moves only when not trapping.
      if (r_state == ST_HOLD && i_retire) begin
        r_instr_valid <= 1'b0;
      end
      if (w_advance) begin
        r_pc <= w_next_pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign_err;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_misalign_err <= 1'b0;
    end else if (r_state == ST_HOLD && i_retire && w_misaligned) begin
      r_misalign_err <= 1'b1;
    end
  end
  assign o_misalign_err = r_misalign_err;
`else
  assign o_misalign_err = 1'b0;
`endif

  assign o_imem_req    = (r_state == ST_FETCH);
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_op          = r_instr_valid ? r_instr[6:0] : 7'b0000000;
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_state       = r_state;

endmodule
